// File: rtl/scandoubler_vidmem_arb.sv
// ---------------------------------------------------------------------------
// scandoubler_vidmem_arb
//
// Purpose: arbitrates one external video memory between a write client
// (incoming video, vidin_*) and a read client (scandoubled output, vidout_*).
// Every memory access is a fixed burst of 8 sequential words.
//
// Word address = BASE_ADDR + {frame[1:0], y, x}, truncated to ADDR_WIDTH.
//
// Handshakes: a client holds *_req high while it has work. vidin_ack pulses
// in the same cycle the memory takes a word (mem_wack); the next word must
// already be on vidin_d in the following cycle. vidout_ack marks a valid
// vidout_d and trails mem_rvalid by exactly one cycle. mem_req stays high
// for the whole burst; mem_we tells write from read bursts.
//
// Ports:
//   clk_sys, reset        sole clock, synchronous active-high reset
//   vidin_req/frame/x/y/d write client request, coordinates and data
//   vidin_ack             write word consumed
//   vidout_req/frame/x/y  read client row request and coordinates
//   vidout_d/vidout_ack   read data and its valid strobe
//   mem_req/we/addr/wdata memory command and write data
//   mem_wack              memory took a write word
//   mem_rdata/mem_rvalid  memory read data and valid
//   busy                  arbiter not idle
//   dbg_state_o           current FSM state (debug)
//
// Build option: define VIDMEM_ARB_STARVE_EN to let a waiting write win
// after STARVE_LIMIT consecutive read bursts; otherwise reads always win.
// ---------------------------------------------------------------------------
module scandoubler_vidmem_arb #(
    parameter int                    HCNT_WIDTH   = 10,
    parameter int                    ADDR_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    STARVE_LIMIT = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  vidin_req,
    input  logic [1:0]            vidin_frame,
    input  logic [HCNT_WIDTH-1:0] vidin_x,
    input  logic [HCNT_WIDTH-1:0] vidin_y,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,
    input  logic                  vidout_req,
    input  logic [1:0]            vidout_frame,
    input  logic [HCNT_WIDTH-1:0] vidout_x,
    input  logic [HCNT_WIDTH-1:0] vidout_y,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_wack,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  busy,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2
    } state_e;

    localparam int FIELD_W = 2 + 2 * HCNT_WIDTH;
    localparam int SUM_W   = (FIELD_W > ADDR_WIDTH) ? FIELD_W : ADDR_WIDTH;

    function automatic logic [ADDR_WIDTH-1:0] make_addr(
        input logic [1:0]            f,
        input logic [HCNT_WIDTH-1:0] y,
        input logic [HCNT_WIDTH-1:0] x
    );
        logic [SUM_W-1:0] sum;
        sum = SUM_W'({f, y, x}) + SUM_W'(BASE_ADDR);
        return sum[ADDR_WIDTH-1:0];
    endfunction

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [HCNT_WIDTH-1:0]   row_x_q, row_x_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    armed_q;        // low for the first edge after reset
    logic                    vout_req_q;     // previous vidout_req, for edge detect
    logic [15:0]             vidout_d_q;
    logic                    vidout_ack_q;

    logic                    rd_edge;
    logic [HCNT_WIDTH-1:0]   rd_x;
    logic                    grant_wr;

    // A new row starts at vidout_x; later bursts continue from row_x_q.
    assign rd_edge = vidout_req && !vout_req_q;
    assign rd_x    = rd_edge ? vidout_x : row_x_q;

`ifdef VIDMEM_ARB_STARVE_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    logic [STARVE_W-1:0] starve_q, starve_d;

    assign grant_wr = vidin_req && (!vidout_req || (starve_q == STARVE_W'(STARVE_LIMIT)));
`else
    // STARVE_LIMIT has no effect when starvation relief is compiled out.
    logic unused_starve_limit;
    assign unused_starve_limit = ^STARVE_LIMIT;

    assign grant_wr = vidin_req && !vidout_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        row_x_d    = rd_x;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
`ifdef VIDMEM_ARB_STARVE_EN
        starve_d   = vidin_req ? starve_q : '0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                if (armed_q) begin
                    if (grant_wr) begin
                        state_d    = ST_WR;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b1;
                        mem_addr_d = make_addr(vidin_frame, vidin_y, vidin_x);
`ifdef VIDMEM_ARB_STARVE_EN
                        starve_d   = '0;
`endif
                    end else if (vidout_req) begin
                        state_d    = ST_RD;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = make_addr(vidout_frame, vidout_y, rd_x);
                        // Advancing at burst start keeps the next burst's x
                        // correct even if a new row edge lands mid-burst.
                        row_x_d    = rd_x + HCNT_WIDTH'(8);
                    end
                end
            end
            ST_WR: begin
                if (mem_wack) begin
                    cnt_d      = cnt_q + 3'd1;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    if (cnt_q == 3'd7) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (mem_rvalid) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
`ifdef VIDMEM_ARB_STARVE_EN
                        if (vidin_req && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
`endif
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            row_x_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            armed_q      <= 1'b0;
            vout_req_q   <= 1'b0;
            vidout_d_q   <= 16'd0;
            vidout_ack_q <= 1'b0;
`ifdef VIDMEM_ARB_STARVE_EN
            starve_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_x_q      <= row_x_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            armed_q      <= 1'b1;
            vout_req_q   <= vidout_req;
            vidout_d_q   <= mem_rdata;
            vidout_ack_q <= (state_q == ST_RD) && mem_rvalid;
`ifdef VIDMEM_ARB_STARVE_EN
            starve_q     <= starve_d;
`endif
        end
    end

    assign vidin_ack   = (state_q == ST_WR) && mem_wack && !reset;
    assign mem_wdata   = vidin_d;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign vidout_d    = vidout_d_q;
    assign vidout_ack  = vidout_ack_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_scandoubler_vidmem_arb.sv
// ---------------------------------------------------------------------------
// tb_scandoubler_vidmem_arb
//
// Directed bench for scandoubler_vidmem_arb (HCNT_WIDTH=10, ADDR_WIDTH=24,
// BASE_ADDR=0, STARVE_LIMIT=4). Write addresses and read data words are
// queued when driven and popped when the arbiter presents them.
// ---------------------------------------------------------------------------
module tb_scandoubler_vidmem_arb;

    logic        clk;
    logic        reset;
    logic        vidin_req;
    logic [1:0]  vidin_frame;
    logic [9:0]  vidin_x;
    logic [9:0]  vidin_y;
    logic [15:0] vidin_d;
    logic        vidin_ack;
    logic        vidout_req;
    logic [1:0]  vidout_frame;
    logic [9:0]  vidout_x;
    logic [9:0]  vidout_y;
    logic [15:0] vidout_d;
    logic        vidout_ack;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_wack;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        busy;
    logic [1:0]  dbg_state;

    int vec_cnt  = 0;
    int fail_cnt = 0;
    int ack_seen = 0;
    bit prev_v   = 1'b0;

    logic [23:0] exp_q[$];     // expected write addresses
    logic [15:0] rd_exp_q[$];  // expected read data words

    scandoubler_vidmem_arb #(
        .HCNT_WIDTH  (10),
        .ADDR_WIDTH  (24),
        .BASE_ADDR   (24'd0),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_sys     (clk),
        .reset       (reset),
        .vidin_req   (vidin_req),
        .vidin_frame (vidin_frame),
        .vidin_x     (vidin_x),
        .vidin_y     (vidin_y),
        .vidin_d     (vidin_d),
        .vidin_ack   (vidin_ack),
        .vidout_req  (vidout_req),
        .vidout_frame(vidout_frame),
        .vidout_x    (vidout_x),
        .vidout_y    (vidout_y),
        .vidout_d    (vidout_d),
        .vidout_ack  (vidout_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wack    (mem_wack),
        .mem_rdata   (mem_rdata),
        .mem_rvalid  (mem_rvalid),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Steps cycles until mem_req is seen, bounded.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (mem_req !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, mem_req, 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle_req", mem_req, 0);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic write_burst(input logic [23:0] base);
        logic [15:0] d;
        for (int i = 0; i < 8; i++) exp_q.push_back(base + 24'(i));
        wait_req("wr_start");
        check("wr_we", mem_we, 1);
        check("wr_state", dbg_state, 1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            d        = 16'($urandom_range(0, 65535));
            vidin_d  = d;
            mem_wack = 1'b1;
            if (i == 7) begin
                vidin_req  = 1'b0;
                vidout_req = 1'b0;
            end
            #1;
            check("wr_req", mem_req, 1);
            check("wr_addr", mem_addr, exp_q.pop_front());
            check("wr_data", mem_wdata, d);
            check("wr_ack", vidin_ack, 1);
        end
        @(posedge clk); #1;
        #1;
        check("wr_end_busy", busy, 0);
        check("wr_end_req", mem_req, 0);
        check("wr_idle_ack", vidin_ack, 0);
        mem_wack = 1'b0;
    endtask

    task automatic rd_tick(input bit v, input bit exp_req);
        logic [15:0] d;
        @(posedge clk); #1;
        check("rd_ack", vidout_ack, prev_v);
        if (vidout_ack === 1'b1) begin
            ack_seen++;
            if (rd_exp_q.size() > 0) begin
                check("rd_data", vidout_d, rd_exp_q.pop_front());
            end else begin
                vec_cnt++;
                fail_cnt++;
                $error("FAIL rd_underflow: observed ack with data %0h, expected no ack", vidout_d);
            end
        end
        check("rd_req", mem_req, exp_req);
        d          = 16'($urandom_range(0, 65535));
        mem_rdata  = d;
        mem_rvalid = v;
        if (v) rd_exp_q.push_back(d);
        prev_v = v;
    endtask

    // Read data arrives 3 cycles after mem_req rises; drop_at < 0 keeps vidout_req.
    task automatic read_burst(input logic [23:0] addr, input int drop_at);
        wait_req("rd_start");
        check("rd_we", mem_we, 0);
        check("rd_addr", mem_addr, addr);
        check("rd_state", dbg_state, 2);
        rd_tick(1'b0, 1'b1);
        rd_tick(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            rd_tick(1'b1, 1'b1);
            if (k == drop_at) vidout_req = 1'b0;
        end
        rd_tick(1'b0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset        = 1'b1;
        vidin_req    = 1'b0;
        vidin_frame  = 2'd0;
        vidin_x      = 10'd0;
        vidin_y      = 10'd0;
        vidin_d      = 16'hBEEF;
        vidout_req   = 1'b0;
        vidout_frame = 2'd0;
        vidout_x     = 10'd0;
        vidout_y     = 10'd0;
        mem_wack     = 1'b0;
        mem_rdata    = 16'd0;
        mem_rvalid   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_vidin_ack", vidin_ack, 0);
        check("rst_vidout_ack", vidout_ack, 0);
        check("rst_vidout_d", vidout_d, 0);
        check("rst_wdata_follow", mem_wdata, 16'hBEEF);
        check("rst_state", dbg_state, 0);

        // Write burst, request already pending at reset release.
        reset       = 1'b0;
        vidin_req   = 1'b1;
        vidin_frame = 2'd1;
        vidin_y     = 10'd3;
        vidin_x     = 10'd16;
        @(posedge clk); #1;
        check("no_grant_first_edge", busy, 0);
        write_burst(24'h100C10);

        // Read row of 24 words at y=5, x=0.
        ack_seen     = 0;
        vidout_frame = 2'd0;
        vidout_y     = 10'd5;
        vidout_x     = 10'd0;
        vidout_req   = 1'b1;
        read_burst(24'h001400, -1);
        read_burst(24'h001408, -1);
        read_burst(24'h001410, 7);
        idle_cycles(4);
        check("row_ack_count", ack_seen, 24);

        // Row starting at x=1020 wraps; request dropped mid second burst.
        ack_seen     = 0;
        vidout_frame = 2'd2;
        vidout_y     = 10'd2;
        vidout_x     = 10'd1020;
        vidout_req   = 1'b1;
        read_burst(24'h200BFC, -1);
        read_burst(24'h200804, 3);
        idle_cycles(6);
        check("wrap_ack_count", ack_seen, 16);
        check("rd_queue_empty", rd_exp_q.size(), 0);

        // Simultaneous requests: read first, write only by starvation relief.
        vidout_frame = 2'd0;
        vidout_y     = 10'd1;
        vidout_x     = 10'd0;
        vidin_frame  = 2'd3;
        vidin_y      = 10'd7;
        vidin_x      = 10'd40;
        vidin_req    = 1'b1;
        vidout_req   = 1'b1;
        read_burst(24'h000400, -1);
        read_burst(24'h000408, -1);
        read_burst(24'h000410, -1);
        read_burst(24'h000418, -1);
`ifndef VIDMEM_ARB_STARVE_EN
        read_burst(24'h000420, 7);
`endif
        write_burst(24'h301C28);
        idle_cycles(4);

        // Reset in the middle of a write burst.
        vidin_frame = 2'd0;
        vidin_y     = 10'd0;
        vidin_x     = 10'd8;
        vidin_req   = 1'b1;
        wait_req("rst_wr_start");
        check("rst_wr_we", mem_we, 1);
        check("rst_wr_addr", mem_addr, 24'h000008);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            mem_wack = 1'b1;
            #1;
            check("rst_wr_ack", vidin_ack, 1);
        end
        @(posedge clk); #1;
        reset     = 1'b1;
        mem_wack  = 1'b0;
        vidin_req = 1'b0;
        @(posedge clk); #1;
        check("midrst_req", mem_req, 0);
        check("midrst_busy", busy, 0);
        check("midrst_we", mem_we, 0);
        check("midrst_addr", mem_addr, 0);
        reset      = 1'b0;
        mem_wack   = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        check("stray_wack", vidin_ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stray_wack_later", vidin_ack, 0);
            check("stray_rvalid", vidout_ack, 0);
            check("stray_busy", busy, 0);
        end
        mem_wack   = 1'b0;
        mem_rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
        $finish;
    end

endmodule
